// File: rtl/rx_fragment_dispatcher_if.sv
// rx_fragment_dispatcher_if: two filter fragment slots in, one DLL head entry plus status flags out
// master: filter/DLL side (drives slots and i_Ready, observes head and status)
// slave: dispatcher side (consumes slots and i_Ready, drives head and status)
interface rx_fragment_dispatcher_if #(
  parameter int SYMBOL_WIDTH     = 8,
  parameter int MAX_LANES        = 32,
  parameter int SYMBOL_PTR_WIDTH = 5,
  parameter int PACKET_LENGTH    = 11
);
  localparam int DW = SYMBOL_WIDTH * MAX_LANES;
  logic                        i_Wr_EN, i_Valid_2;
  logic [DW-1:0]               i_Data1, i_Data2;
  logic                        i_SOP1, i_SOP2, i_End_Valid1, i_End_Valid2, i_Type1, i_Type2;
  logic [SYMBOL_PTR_WIDTH-1:0] i_Last_Byte1, i_Last_Byte2;
  logic [PACKET_LENGTH-1:0]    i_Length1, i_Length2;
  logic                        o_Valid, i_Ready;
  logic [DW-1:0]               o_Data;
  logic                        o_SOP, o_End_Valid, o_Type;
  logic [SYMBOL_PTR_WIDTH-1:0] o_Last_Byte;
  logic [PACKET_LENGTH-1:0]    o_Length;
  logic                        o_Almost_Full, o_Overflow, o_Frame_Err;
  modport master (
    output i_Wr_EN, i_Valid_2, i_Data1, i_Data2, i_SOP1, i_SOP2, i_End_Valid1, i_End_Valid2,
           i_Type1, i_Type2, i_Last_Byte1, i_Last_Byte2, i_Length1, i_Length2, i_Ready,
    input  o_Valid, o_Data, o_SOP, o_End_Valid, o_Type, o_Last_Byte, o_Length,
           o_Almost_Full, o_Overflow, o_Frame_Err
  );
  modport slave (
    input  i_Wr_EN, i_Valid_2, i_Data1, i_Data2, i_SOP1, i_SOP2, i_End_Valid1, i_End_Valid2,
           i_Type1, i_Type2, i_Last_Byte1, i_Last_Byte2, i_Length1, i_Length2, i_Ready,
    output o_Valid, o_Data, o_SOP, o_End_Valid, o_Type, o_Last_Byte, o_Length,
           o_Almost_Full, o_Overflow, o_Frame_Err
  );
endinterface

// File: rtl/rx_fragment_dispatcher.sv
// rx_fragment_dispatcher: stages up to two filtered fragments per cycle in order and dispatches one per cycle to the DLL
// CLK/RST: clock and synchronous active-high reset; i_Flush: soft flush (pointers, flags, FSM, memory)
// bus: slot 1/2 fragment inputs, head entry valid/ready handshake, o_Almost_Full, o_Overflow, o_Frame_Err
// RX_DISPATCH_STATS_EN: adds o_Pkt_Cnt, count of popped end-of-packet entries, cleared only by RST
module rx_fragment_dispatcher #(
  parameter int SYMBOL_WIDTH     = 8,
  parameter int MAX_LANES        = 32,
  parameter int SYMBOL_PTR_WIDTH = 5,
  parameter int PACKET_LENGTH    = 11,
  parameter int DEPTH            = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_Flush,
`ifdef RX_DISPATCH_STATS_EN
  output logic [15:0] o_Pkt_Cnt,
`endif
  rx_fragment_dispatcher_if.slave bus
);
  localparam int DW = SYMBOL_WIDTH * MAX_LANES;
  localparam int EW = DW + SYMBOL_PTR_WIDTH + PACKET_LENGTH + 3;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, IN_PKT} state_t;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] ent1, ent2;
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] cnt_q, cnt_d, n, acc, free;
  logic          clr, pop, drop, ovf_q, ferr_q, ferr_d, af_q;
  state_t        state_q, state_d, st1;
  function automatic state_t step(state_t s, logic sop, logic eop);
    return (sop || s == IN_PKT) ? (eop ? IDLE : IN_PKT) : IDLE;
  endfunction
  assign clr  = RST | i_Flush;
  assign ent1 = {bus.i_Data1, bus.i_SOP1, bus.i_End_Valid1, bus.i_Last_Byte1, bus.i_Type1, bus.i_Length1};
  assign ent2 = {bus.i_Data2, bus.i_SOP2, bus.i_End_Valid2, bus.i_Last_Byte2, bus.i_Type2, bus.i_Length2};
  assign {bus.o_Data, bus.o_SOP, bus.o_End_Valid, bus.o_Last_Byte, bus.o_Type, bus.o_Length} = mem_q[head_q];
  assign bus.o_Valid       = cnt_q != '0;
  assign bus.o_Almost_Full = af_q;
  assign bus.o_Overflow    = ovf_q;
  assign bus.o_Frame_Err   = ferr_q;
  // a flush suppresses the pop so neither the queue nor the packet counter moves
  assign pop   = bus.o_Valid & bus.i_Ready & ~i_Flush;
  assign n     = CW'(bus.i_Wr_EN) + CW'(bus.i_Wr_EN & bus.i_Valid_2);
  assign free  = CW'(DEPTH) - cnt_q + CW'(pop);
  assign drop  = n > free;
  assign acc   = drop ? '0 : n;
  assign cnt_d = cnt_q + acc - CW'(pop);
  always_ff @(posedge CLK) state_q <= clr ? IDLE : state_d;
  always_comb begin
    st1     = acc != '0 ? step(state_q, bus.i_SOP1, bus.i_End_Valid1) : state_q;
    state_d = acc == CW'(2) ? step(st1, bus.i_SOP2, bus.i_End_Valid2) : st1;
  end
  // a fragment is out of sequence when its SOP disagrees with being idle
  always_comb begin
    ferr_d = (acc != '0 && (bus.i_SOP1 ^ (state_q == IDLE))) ||
             (acc == CW'(2) && (bus.i_SOP2 ^ (st1 == IDLE)));
  end
  always_ff @(posedge CLK) begin
    if (clr) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
      af_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (acc != '0) mem_q[tail_q] <= ent1;
      if (acc == CW'(2)) mem_q[tail_q + AW'(1)] <= ent2;
      tail_q <= tail_q + acc[AW-1:0];
      head_q <= head_q + AW'(pop);
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_q | drop;
      ferr_q <= ferr_d;
      af_q   <= (CW'(DEPTH) - cnt_d) < CW'(2);
    end
  end
`ifdef RX_DISPATCH_STATS_EN
  logic [15:0] pkt_cnt_q;
  always_ff @(posedge CLK) pkt_cnt_q <= RST ? '0 : pkt_cnt_q + 16'(pop & bus.o_End_Valid);
  assign o_Pkt_Cnt = pkt_cnt_q;
`endif
endmodule

// File: tb/tb_rx_fragment_dispatcher.sv
// tb_rx_fragment_dispatcher: directed and randomized checks of the dispatcher against a queue-based model
module tb_rx_fragment_dispatcher;
  localparam int DEPTH = 4;
  localparam int DW    = 256;
  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop, eop;
    logic [4:0]    lb;
    logic          typ;
    logic [10:0]   len;
  } frag_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  always #5 clk = ~clk;
  rx_fragment_dispatcher_if ifc ();
`ifdef RX_DISPATCH_STATS_EN
  logic [15:0] pkt_cnt;
`endif
  rx_fragment_dispatcher #(.DEPTH(DEPTH)) dut (
    .CLK(clk),
    .RST(rst),
    .i_Flush(flush),
`ifdef RX_DISPATCH_STATS_EN
    .o_Pkt_Cnt(pkt_cnt),
`endif
    .bus(ifc)
  );
  int    vectors = 0, errors = 0;
  frag_t mq[$];
  bit    m_in_pkt, m_ovf, m_ferr, m_af, armed;
  logic [15:0] m_pkt;
  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk1(string name, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  function automatic frag_t mk(logic [7:0] d, bit sop, bit eop);
    return {{32{d}}, sop, eop, 5'd31, 1'b0, 11'd1};
  endfunction
  function automatic frag_t rnd();
    frag_t f;
    for (int k = 0; k < DW / 32; k++) f.data[k*32 +: 32] = $urandom;
    f.sop = 1'($urandom_range(0, 1));
    f.eop = 1'($urandom_range(0, 1));
    f.lb  = 5'($urandom);
    f.typ = 1'($urandom);
    f.len = 11'($urandom);
    return f;
  endfunction
  task automatic drive(bit wr, bit v2, frag_t a, frag_t b);
    ifc.i_Wr_EN   = wr;
    ifc.i_Valid_2 = v2;
    {ifc.i_Data1, ifc.i_SOP1, ifc.i_End_Valid1, ifc.i_Last_Byte1, ifc.i_Type1, ifc.i_Length1} = a;
    {ifc.i_Data2, ifc.i_SOP2, ifc.i_End_Valid2, ifc.i_Last_Byte2, ifc.i_Type2, ifc.i_Length2} = b;
  endtask
  task automatic accept(frag_t f);
    if (f.sop ? m_in_pkt : !m_in_pkt) m_ferr = 1'b1;
    m_in_pkt = (f.sop || m_in_pkt) && !f.eop;
    mq.push_back(f);
  endtask
  task automatic model_step();
    frag_t a, b;
    int    n;
    a = {ifc.i_Data1, ifc.i_SOP1, ifc.i_End_Valid1, ifc.i_Last_Byte1, ifc.i_Type1, ifc.i_Length1};
    b = {ifc.i_Data2, ifc.i_SOP2, ifc.i_End_Valid2, ifc.i_Last_Byte2, ifc.i_Type2, ifc.i_Length2};
    if (rst || flush) begin
      mq.delete();
      m_in_pkt = 1'b0;
      m_ovf    = 1'b0;
      m_ferr   = 1'b0;
      m_af     = 1'b0;
      if (rst) m_pkt = '0;
    end else begin
      if (mq.size() != 0 && ifc.i_Ready) begin
        if (mq[0].eop) m_pkt = m_pkt + 16'd1;
        void'(mq.pop_front());
      end
      n      = ifc.i_Wr_EN ? (ifc.i_Valid_2 ? 2 : 1) : 0;
      m_ferr = 1'b0;
      if (n > DEPTH - mq.size()) m_ovf = 1'b1;
      else begin
        if (n >= 1) accept(a);
        if (n == 2) accept(b);
      end
      m_af = (DEPTH - mq.size()) < 2;
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    armed = 1'b1;
  endtask
  always @(negedge clk) begin
    if (armed) begin
      chk1("valid", ifc.o_Valid, mq.size() != 0);
      chk1("almost_full", ifc.o_Almost_Full, m_af);
      chk1("overflow", ifc.o_Overflow, m_ovf);
      chk1("frame_err", ifc.o_Frame_Err, m_ferr);
      if (mq.size() != 0) begin
        chk("head_data", ifc.o_Data, mq[0].data);
        chk1("head_sop", ifc.o_SOP, mq[0].sop);
        chk1("head_end", ifc.o_End_Valid, mq[0].eop);
        chk1("head_type", ifc.o_Type, mq[0].typ);
        chk("head_last_byte", DW'(ifc.o_Last_Byte), DW'(mq[0].lb));
        chk("head_length", DW'(ifc.o_Length), DW'(mq[0].len));
      end
`ifdef RX_DISPATCH_STATS_EN
      chk("pkt_cnt", DW'(pkt_cnt), DW'(m_pkt));
`endif
    end
  end
  initial begin
    frag_t z;
    logic [7:0] d;
    z = '0;
    ifc.i_Ready = 1'b0;
    drive(0, 0, z, z);
    cyc();
    cyc();
    rst = 1'b0;
    chk1("reset_valid", ifc.o_Valid, 1'b0);
    chk("reset_data", ifc.o_Data, '0);
    chk1("reset_af", ifc.o_Almost_Full, 1'b0);
    chk1("reset_ovf", ifc.o_Overflow, 1'b0);
    chk1("reset_ferr", ifc.o_Frame_Err, 1'b0);
    ifc.i_Ready = 1'b1;
    drive(1, 0, mk(8'hA5, 1, 1), z);
    cyc();
    drive(0, 0, z, z);
    chk1("single_valid", ifc.o_Valid, 1'b1);
    chk("single_data", ifc.o_Data, {32{8'hA5}});
    cyc();
    chk1("single_drained", ifc.o_Valid, 1'b0);
    chk1("single_ferr", ifc.o_Frame_Err, 1'b0);
    drive(1, 1, mk(8'h11, 1, 0), mk(8'h22, 0, 1));
    cyc();
    drive(0, 0, z, z);
    chk("dual_first", ifc.o_Data, {32{8'h11}});
    cyc();
    chk("dual_second", ifc.o_Data, {32{8'h22}});
    chk1("dual_ferr", ifc.o_Frame_Err, 1'b0);
    cyc();
    chk1("dual_drained", ifc.o_Valid, 1'b0);
    ifc.i_Ready = 1'b0;
    drive(1, 1, mk(8'h31, 1, 1), mk(8'h32, 1, 1));
    cyc();
    chk1("fill_af_half", ifc.o_Almost_Full, 1'b0);
    drive(1, 1, mk(8'h33, 1, 1), mk(8'h34, 1, 1));
    cyc();
    chk1("fill_af_full", ifc.o_Almost_Full, 1'b1);
    chk1("fill_no_ovf", ifc.o_Overflow, 1'b0);
    drive(1, 1, mk(8'h35, 1, 1), mk(8'h36, 1, 1));
    cyc();
    drive(0, 0, z, z);
    chk1("fill_ovf", ifc.o_Overflow, 1'b1);
    ifc.i_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'h31 + 8'(i);
      chk("drain_order", ifc.o_Data, {32{d}});
      cyc();
    end
    chk1("drain_empty", ifc.o_Valid, 1'b0);
    chk1("ovf_sticky", ifc.o_Overflow, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk1("flush_ovf_clear", ifc.o_Overflow, 1'b0);
    ifc.i_Ready = 1'b0;
    drive(1, 1, mk(8'h41, 1, 1), mk(8'h42, 1, 1));
    cyc();
    drive(1, 1, mk(8'h43, 1, 1), mk(8'h44, 1, 1));
    cyc();
    ifc.i_Ready = 1'b1;
    drive(1, 0, mk(8'h45, 1, 1), z);
    cyc();
    drive(0, 0, z, z);
    ifc.i_Ready = 1'b0;
    chk1("full_pushpop_ovf", ifc.o_Overflow, 1'b0);
    chk1("full_pushpop_af", ifc.o_Almost_Full, 1'b1);
    chk("full_pushpop_head", ifc.o_Data, {32{8'h42}});
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1, 0, mk(8'h51, 0, 1), z);
    cyc();
    drive(0, 0, z, z);
    chk1("err_idle_nosop", ifc.o_Frame_Err, 1'b1);
    chk1("err_queued", ifc.o_Valid, 1'b1);
    cyc();
    chk1("err_pulse_end", ifc.o_Frame_Err, 1'b0);
    drive(1, 0, mk(8'h52, 1, 0), z);
    cyc();
    chk1("pkt_start_ok", ifc.o_Frame_Err, 1'b0);
    drive(1, 0, mk(8'h53, 1, 0), z);
    cyc();
    drive(0, 0, z, z);
    chk1("err_sop_in_pkt", ifc.o_Frame_Err, 1'b1);
    cyc();
    chk1("err_sop_pulse_end", ifc.o_Frame_Err, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk1("flush_empty", ifc.o_Valid, 1'b0);
    drive(1, 0, mk(8'h54, 0, 1), z);
    cyc();
    drive(0, 0, z, z);
    chk1("flush_fsm_idle", ifc.o_Frame_Err, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      rst         = $urandom_range(0, 299) == 0;
      flush       = $urandom_range(0, 63) == 0;
      ifc.i_Ready = $urandom_range(0, 9) < 6;
      drive($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), rnd(), rnd());
      cyc();
    end
    rst   = 1'b0;
    flush = 1'b0;
    drive(0, 0, z, z);
    cyc();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
